// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {OP_MUL, OP_MULU, OP_DIV, OP_DIVU} op_e;
    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX} state_e;

    localparam int MD_ITERS = 32;

    function automatic logic op_is_div(input op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input op_e op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Start/busy handshake and HI/LO result bus between the controller and the unit.
interface muldiv_if #(parameter int WIDTH = 32);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mul_start;
    logic             mulu_start;
    logic             div_start;
    logic             divu_start;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             dz;

    modport master (
        output a, b, mul_start, mulu_start, div_start, divu_start,
        input  busy, done, hi, lo, dz
    );

    modport slave (
        input  a, b, mul_start, mulu_start, div_start, divu_start,
        output busy, done, hi, lo, dz
    );

endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   opnd,
    output logic [2*WIDTH-1:0] acc_next,
    output logic               q_bit
);

    logic [WIDTH:0] add_x;
    logic [WIDTH:0] add_y;
    logic [WIDTH:0] sum;

    // Single W+1 bit adder; divide subtracts via ~y + 1.
    always_comb begin
        if (is_div) begin
            add_x = acc[2*WIDTH-1:WIDTH-1];
            add_y = ~{1'b0, opnd};
        end else begin
            add_x = {1'b0, acc[2*WIDTH-1:WIDTH]};
            add_y = acc[0] ? {1'b0, opnd} : '0;
        end
        sum   = add_x + add_y + {{WIDTH{1'b0}}, is_div};
        q_bit = is_div & ~sum[WIDTH];

        // Divide leaves the LSB for the caller to fill with q_bit.
        if (!is_div)
            acc_next = {sum, acc[WIDTH-1:1]};
        else if (q_bit)
            acc_next = {sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        else
            acc_next = {acc[2*WIDTH-2:0], 1'b0};
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-bit mul/mulu/div/divu responder; magnitudes iterate, signs are fixed up in FIX.
// state  | meaning
// S_IDLE | waiting for an armed start; busy follows the request combinationally
// S_ITER | ITERS radix-2 steps on the 2W accumulator
// S_FIX  | apply sign rules, register hi/lo/dz
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITERS = MD_ITERS
) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);

    localparam int CW = $clog2(ITERS);

    state_e             state_q, state_d;
    op_e                op_q, op_d, op_sel;
    logic               sa_q, sa_d, sb_q, sb_d;
    logic               arm_q, arm_d, done_q, done_d, dz_q, dz_d, zdiv_q, zdiv_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, step_acc, prod;
    logic               req, accept, step_q, sel_sa, sel_sb;
    logic [WIDTH-1:0]   mag_a, mag_b, quo, rem;

    assign req    = bus.mul_start | bus.mulu_start | bus.div_start | bus.divu_start;
    assign accept = (state_q == S_IDLE) & req & arm_q;

    always_comb begin
        op_sel = OP_DIVU;
        if (bus.mul_start)       op_sel = OP_MUL;
        else if (bus.mulu_start) op_sel = OP_MULU;
        else if (bus.div_start)  op_sel = OP_DIV;
    end

    assign sel_sa = op_is_signed(op_sel) & bus.a[WIDTH-1];
    assign sel_sb = op_is_signed(op_sel) & bus.b[WIDTH-1];
    assign mag_a  = sel_sa ? -bus.a : bus.a;
    assign mag_b  = sel_sb ? -bus.b : bus.b;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (op_is_div(op_q)),
        .acc      (acc_q),
        .opnd     (opnd_q),
        .acc_next (step_acc),
        .q_bit    (step_q)
    );

    assign prod = (sa_q ^ sb_q) ? -acc_q : acc_q;
    assign quo  = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem  = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        zdiv_d  = zdiv_q;
        cnt_d   = cnt_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
        // A level start held through completion cannot relaunch until it drops.
        arm_d   = accept ? 1'b0 : (req ? arm_q : 1'b1);

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_ITER;
                    op_d    = op_sel;
                    sa_d    = sel_sa;
                    sb_d    = sel_sb;
                    cnt_d   = '0;
                    dz_d    = 1'b0;
                    zdiv_d  = op_is_div(op_sel) && (bus.b == '0);
                    if (op_is_div(op_sel)) begin
                        acc_d  = {{WIDTH{1'b0}}, mag_a};
                        opnd_d = mag_b;
                    end else begin
                        acc_d  = {{WIDTH{1'b0}}, mag_b};
                        opnd_d = mag_a;
                    end
                end
            end
            S_ITER: begin
                acc_d = {step_acc[2*WIDTH-1:1], op_is_div(op_q) ? step_q : step_acc[0]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(ITERS - 1))
                    state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (op_is_div(op_q)) begin
                    // Divisor 0 yields remainder |a|, so the sign rule restores a exactly.
                    hi_d = rem;
                    lo_d = zdiv_q ? '1 : quo;
                    dz_d = zdiv_q;
                end else begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                    dz_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_MUL;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            zdiv_q  <= 1'b0;
            cnt_q   <= '0;
            opnd_q  <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
            arm_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            zdiv_q  <= zdiv_d;
            cnt_q   <= cnt_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
            arm_q   <= arm_d;
        end
    end

    assign bus.busy = accept | (state_q != S_IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.dz   = dz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: random and directed ops checked against 64-bit arithmetic.
module tb_muldiv_unit;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t last = '0;

    muldiv_if #(.WIDTH(32)) bus();

    muldiv_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: the lowest set mask bit wins (mul, mulu, div, divu), then plain 64-bit arithmetic.
    function automatic exp_t model(input logic [3:0] mask, input logic [31:0] a, input logic [31:0] b);
        exp_t           e;
        longint         sx, sy, sq, sr;
        longint unsigned ux, uy, uq, ur;
        e = '0;
        sx = longint'($signed(a));
        sy = longint'($signed(b));
        ux = {32'h0, a};
        uy = {32'h0, b};
        if (mask[0]) begin
            sq = sx * sy;
            e.hi = sq[63:32]; e.lo = sq[31:0];
        end else if (mask[1]) begin
            uq = ux * uy;
            e.hi = uq[63:32]; e.lo = uq[31:0];
        end else if (b == 32'h0) begin
            e.hi = a; e.lo = 32'hFFFF_FFFF; e.dz = 1'b1;
        end else if (mask[2]) begin
            sq = sx / sy; sr = sx % sy;
            e.hi = sr[31:0]; e.lo = sq[31:0];
        end else begin
            uq = ux / uy; ur = ux % uy;
            e.hi = ur[31:0]; e.lo = uq[31:0];
        end
        return e;
    endfunction

    task automatic drive(input logic [3:0] m);
        bus.mul_start  = m[0];
        bus.mulu_start = m[1];
        bus.div_start  = m[2];
        bus.divu_start = m[3];
    endtask

    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=done expected=no_done");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("hi", bus.hi, e.hi);
                chk("lo", bus.lo, e.lo);
                chk("dz", bus.dz, e.dz);
            end
        end
    end

    task automatic run_op(input logic [3:0] mask, input logic [31:0] a, input logic [31:0] b, input int hold);
        exp_t e;
        int   n;
        bit   hold_ok;
        @(negedge clk);
        bus.a = a;
        bus.b = b;
        drive(mask);
        #1;
        chk("busy_on_request", bus.busy, 1);
        e = model(mask, a, b);
        sb.push_back(e);
        n = 1;
        hold_ok = 1'b1;
        for (int i = 1; i < 200; i++) begin
            @(negedge clk);
            if (i >= hold) drive(4'b0);
            #1;
            if (!bus.busy) break;
            n++;
            if (bus.hi !== last.hi || bus.lo !== last.lo) hold_ok = 1'b0;
        end
        chk("busy_cycles", n, 34);
        chk("hilo_stable_while_busy", hold_ok, 1);
        chk("done_seen", sb.size(), 0);
        for (int i = n + 1; i < hold; i++) begin
            @(negedge clk);
            #1;
            chk("no_relaunch", bus.busy, 0);
        end
        drive(4'b0);
        last = e;
    endtask

    task automatic idle_check(input int k);
        repeat (k) @(negedge clk);
        #1;
        chk("idle_busy", bus.busy, 0);
        chk("idle_hi", bus.hi, last.hi);
        chk("idle_lo", bus.lo, last.lo);
        chk("idle_dz", bus.dz, last.dz);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]  mask;
        logic [31:0] ra, rb;
        int          sel;
        bus.a = '0;
        bus.b = '0;
        drive(4'b0);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_hi", bus.hi, 0);
        chk("rst_lo", bus.lo, 0);
        chk("rst_dz", bus.dz, 0);
        rst = 1'b0;

        run_op(4'b0010, 32'hFFFF_FFFF, 32'd2, 1);
        idle_check(2);
        run_op(4'b0001, 32'hFFFF_FFFD, 32'd7, 40);
        idle_check(2);
        run_op(4'b0100, 32'hFFFF_FFF9, 32'd2, 1);
        idle_check(1);
        run_op(4'b1000, 32'd100, 32'd0, 1);
        idle_check(3);
        run_op(4'b0101, 32'd6, 32'd3, 1);
        idle_check(1);
        run_op(4'b0100, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        idle_check(1);

        // Abort mid-operation around the eleventh iteration.
        @(negedge clk);
        bus.a = 32'd12345;
        bus.b = 32'd678;
        drive(4'b0010);
        @(negedge clk);
        drive(4'b0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_hi", bus.hi, 0);
        chk("abort_lo", bus.lo, 0);
        chk("abort_done", bus.done, 0);
        sb.delete();
        last = '0;
        @(negedge clk);
        rst = 1'b0;
        idle_check(2);
        run_op(4'b0010, 32'd12345, 32'd678, 1);

        for (int t = 0; t < 40; t++) begin
            mask = 4'($urandom_range(1, 15));
            sel  = $urandom_range(0, 7);
            ra   = (sel == 7) ? 32'h8000_0000 : $urandom;
            rb   = (sel == 0) ? 32'h0 : (sel == 1) ? 32'hFFFF_FFFF : $urandom;
            if (sel == 2) rb = 32'($urandom_range(1, 9));
            run_op(mask, ra, rb, $urandom_range(1, 3));
            idle_check(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
